// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard/stall controller.
package hazard_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } hazState_t;

   localparam logic [1:0]  FWD_RF    = 2'b00;
   localparam logic [1:0]  FWD_WB    = 2'b01;
   localparam logic [1:0]  FWD_MEM   = 2'b10;
   localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

   function automatic logic [31:0] satInc(input logic [31:0] value);
      return (value == COUNT_MAX) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/hazard_src_eval.sv
// Per-source-register evaluation: stall need (0..2) and ID comparator forward select.
module hazard_src_eval
   import hazard_pkg::*;
(
   input  logic [4:0] srcReg,
   input  logic       srcUsed,
   input  logic       isBranch,
   input  logic       exRegWrite,
   input  logic       exMemRead,
   input  logic [4:0] exDestReg,
   input  logic       memRegWrite,
   input  logic       memMemRead,
   input  logic [4:0] memDestReg,
   input  logic       wbRegWrite,
   input  logic [4:0] wbDestReg,
   output logic [1:0] need,
   output logic [1:0] fwdSel
);

   logic live;
   logic exMatch;
   logic memMatch;
   logic wbMatch;

   // Register 0 is hardwired, so it never matches a producer.
   assign live     = srcUsed && (srcReg != 5'd0);
   assign exMatch  = live && exRegWrite  && (exDestReg  == srcReg);
   assign memMatch = live && memRegWrite && (memDestReg == srcReg);
   assign wbMatch  = live && wbRegWrite  && (wbDestReg  == srcReg);

   always_comb begin
      need = 2'd0;
      if (exMatch && exMemRead) begin
         need = isBranch ? 2'd2 : 2'd1;
      end else if (isBranch && exMatch) begin
         need = 2'd1;
      end else if (isBranch && memMatch && memMemRead) begin
         need = 2'd1;
      end
   end

   // A load still in MEM has no data on the ALU output, so it can only fall back to WB/RF.
   always_comb begin
      fwdSel = FWD_RF;
      if (memMatch && !memMemRead) begin
         fwdSel = FWD_MEM;
      end else if (wbMatch) begin
         fwdSel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_stall_controller.sv
// ID-stage hazard detection: stalls PC/IF-ID, injects bubbles, selects branch operand forwarding.
module hazard_stall_controller
   import hazard_pkg::*;
(
   input  logic        Clock,
   input  logic        Reset,
   input  logic [4:0]  ID_RsReg,
   input  logic [4:0]  ID_RtReg,
   input  logic        ID_UsesRs,
   input  logic        ID_UsesRt,
   input  logic        Branch,
   input  logic        EX_RegWrite,
   input  logic        EX_MemRead,
   input  logic [4:0]  EX_DestReg,
   input  logic        MEM_RegWrite,
   input  logic        MEM_MemRead,
   input  logic [4:0]  MEM_DestReg,
   input  logic        WB_RegWrite,
   input  logic [4:0]  WB_DestReg,
   output logic        PCWrite,
   output logic        IFIDWrite,
   output logic        HazZero,
   output logic [1:0]  ForBranchA,
   output logic [1:0]  ForBranchB,
   output logic [31:0] StallCount
);

   logic [1:0] rsNeed;
   logic [1:0] rtNeed;
   logic [1:0] rsFwd;
   logic [1:0] rtFwd;
   logic [1:0] need;
   logic       stall;
   hazState_t  state;
   logic [1:0] remaining;
   logic [31:0] stallCnt;

   hazard_src_eval rsEval (
      .srcReg      (ID_RsReg),
      .srcUsed     (ID_UsesRs),
      .isBranch    (Branch),
      .exRegWrite  (EX_RegWrite),
      .exMemRead   (EX_MemRead),
      .exDestReg   (EX_DestReg),
      .memRegWrite (MEM_RegWrite),
      .memMemRead  (MEM_MemRead),
      .memDestReg  (MEM_DestReg),
      .wbRegWrite  (WB_RegWrite),
      .wbDestReg   (WB_DestReg),
      .need        (rsNeed),
      .fwdSel      (rsFwd)
   );

   hazard_src_eval rtEval (
      .srcReg      (ID_RtReg),
      .srcUsed     (ID_UsesRt),
      .isBranch    (Branch),
      .exRegWrite  (EX_RegWrite),
      .exMemRead   (EX_MemRead),
      .exDestReg   (EX_DestReg),
      .memRegWrite (MEM_RegWrite),
      .memMemRead  (MEM_MemRead),
      .memDestReg  (MEM_DestReg),
      .wbRegWrite  (WB_RegWrite),
      .wbDestReg   (WB_DestReg),
      .need        (rtNeed),
      .fwdSel      (rtFwd)
   );

   // Both sources stall in parallel, so the longer one covers the shorter.
   assign need = (rsNeed > rtNeed) ? rsNeed : rtNeed;

   always_comb begin
      stall = 1'b0;
      if (!Reset) begin
         stall = (state == HOLD) || (need != 2'd0);
      end
   end

   assign PCWrite    = !stall;
   assign IFIDWrite  = !stall;
   assign HazZero    = stall;
   assign ForBranchA = Reset ? FWD_RF : rsFwd;
   assign ForBranchB = Reset ? FWD_RF : rtFwd;
   assign StallCount = stallCnt;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= RUN;
         remaining <= 2'd0;
         stallCnt  <= '0;
      end else begin
         if (stall) begin
            stallCnt <= satInc(stallCnt);
         end
         case (state)
            RUN: begin
               if (need != 2'd0) begin
                  remaining <= need - 2'd1;
                  state     <= (need > 2'd1) ? HOLD : RUN;
               end
            end
            HOLD: begin
               remaining <= remaining - 2'd1;
               if (remaining <= 2'd1) begin
                  state <= RUN;
               end
            end
            default: begin
               state     <= RUN;
               remaining <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench: vector table, directed multi-cycle sequences, randomized run vs. reference model.
module tb_hazard_stall_controller;

   logic        Clock;
   logic        Reset;
   logic [4:0]  ID_RsReg, ID_RtReg;
   logic        ID_UsesRs, ID_UsesRt, Branch;
   logic        EX_RegWrite, EX_MemRead;
   logic [4:0]  EX_DestReg;
   logic        MEM_RegWrite, MEM_MemRead;
   logic [4:0]  MEM_DestReg;
   logic        WB_RegWrite;
   logic [4:0]  WB_DestReg;
   logic        PCWrite, IFIDWrite, HazZero;
   logic [1:0]  ForBranchA, ForBranchB;
   logic [31:0] StallCount;

   int unsigned total = 0;
   int unsigned bad   = 0;

   hazard_stall_controller dut (
      .Clock(Clock), .Reset(Reset),
      .ID_RsReg(ID_RsReg), .ID_RtReg(ID_RtReg),
      .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .Branch(Branch),
      .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_DestReg(EX_DestReg),
      .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_DestReg(MEM_DestReg),
      .WB_RegWrite(WB_RegWrite), .WB_DestReg(WB_DestReg),
      .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .HazZero(HazZero),
      .ForBranchA(ForBranchA), .ForBranchB(ForBranchB), .StallCount(StallCount)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic [4:0] rs, rt;
      logic       uRs, uRt, br;
      logic       exRW, exMR;
      logic [4:0] exD;
      logic       memRW, memMR;
      logic [4:0] memD;
      logic       wbRW;
      logic [4:0] wbD;
   } vec_t;

   typedef struct {
      vec_t       in;
      logic       stall;
      logic [1:0] fa, fb;
   } tvec_t;

   function automatic vec_t mk(int rs, int rt, bit uRs, bit uRt, bit br,
                               bit exRW, bit exMR, int exD,
                               bit memRW, bit memMR, int memD,
                               bit wbRW, int wbD);
      vec_t v;
      v.rs = 5'(rs); v.rt = 5'(rt); v.uRs = uRs; v.uRt = uRt; v.br = br;
      v.exRW = exRW; v.exMR = exMR; v.exD = 5'(exD);
      v.memRW = memRW; v.memMR = memMR; v.memD = 5'(memD);
      v.wbRW = wbRW; v.wbD = 5'(wbD);
      return v;
   endfunction

   task automatic drive(input vec_t v);
      ID_RsReg = v.rs; ID_RtReg = v.rt; ID_UsesRs = v.uRs; ID_UsesRt = v.uRt; Branch = v.br;
      EX_RegWrite = v.exRW; EX_MemRead = v.exMR; EX_DestReg = v.exD;
      MEM_RegWrite = v.memRW; MEM_MemRead = v.memMR; MEM_DestReg = v.memD;
      WB_RegWrite = v.wbRW; WB_DestReg = v.wbD;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkOut(input string name, input logic s, input logic [1:0] fa, input logic [1:0] fb);
      chk(name, {25'd0, PCWrite, IFIDWrite, HazZero, ForBranchA, ForBranchB},
                {25'd0, ~s, ~s, s, fa, fb});
   endtask

   // Reference model: rules stated directly as "cycles of stall still owed".
   function automatic int srcNeed(logic [4:0] r, logic u, vec_t v);
      bit exHit  = u && r != 0 && v.exRW  && v.exD  == r;
      bit memHit = u && r != 0 && v.memRW && v.memD == r;
      int n = 0;
      if (exHit && v.exMR) n = v.br ? 2 : 1;
      if (v.br && exHit && !v.exMR && n < 1) n = 1;
      if (v.br && memHit && v.memMR && n < 1) n = 1;
      return n;
   endfunction

   function automatic logic [1:0] srcFwd(logic [4:0] r, logic u, vec_t v);
      bit memHit = u && r != 0 && v.memRW && v.memD == r;
      bit wbHit  = u && r != 0 && v.wbRW  && v.wbD  == r;
      if (memHit && !v.memMR) return 2'b10;
      if (wbHit) return 2'b01;
      return 2'b00;
   endfunction

   vec_t idle;
   vec_t lwBeq, lwBeqHold, lwBeqWb, addBeq, addBeqMem, lwAdd, lwAddNext;
   tvec_t tbl[$];

   initial begin
      idle = mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0);
      Reset = 1'b1;
      drive(idle);

      // ---------------- table vectors (each applied fresh from reset) ----------------
      tbl.push_back('{mk(8,9,1,1,0, 0,0,0, 0,0,0, 0,0), 1'b0, 2'b00, 2'b00});
      tbl.push_back('{mk(8,9,1,1,0, 1,1,8, 0,0,0, 0,0), 1'b1, 2'b00, 2'b00});
      tbl.push_back('{mk(8,9,1,1,0, 1,1,9, 0,0,0, 0,0), 1'b1, 2'b00, 2'b00});
      tbl.push_back('{mk(8,9,1,0,0, 1,1,9, 0,0,0, 0,0), 1'b0, 2'b00, 2'b00});
      tbl.push_back('{mk(8,9,1,1,0, 1,0,8, 0,0,0, 0,0), 1'b0, 2'b00, 2'b00});
      tbl.push_back('{mk(8,9,1,1,1, 1,0,9, 0,0,0, 0,0), 1'b1, 2'b00, 2'b00});
      tbl.push_back('{mk(8,9,1,1,1, 0,0,0, 1,1,8, 0,0), 1'b1, 2'b00, 2'b00});
      tbl.push_back('{mk(8,9,1,1,1, 0,0,0, 1,0,9, 0,0), 1'b0, 2'b00, 2'b10});
      tbl.push_back('{mk(8,9,1,1,0, 0,0,0, 1,1,8, 0,0), 1'b0, 2'b00, 2'b00});
      tbl.push_back('{mk(8,9,1,1,1, 0,0,0, 0,0,0, 1,8), 1'b0, 2'b01, 2'b00});
      tbl.push_back('{mk(5,5,1,1,1, 0,0,0, 1,0,5, 1,5), 1'b0, 2'b10, 2'b10});
      tbl.push_back('{mk(5,6,1,1,1, 0,0,0, 1,1,5, 1,5), 1'b1, 2'b01, 2'b00});
      tbl.push_back('{mk(0,0,1,1,1, 1,1,0, 1,0,0, 1,0), 1'b0, 2'b00, 2'b00});
      tbl.push_back('{mk(8,9,1,1,1, 0,0,0, 0,0,8, 0,0), 1'b0, 2'b00, 2'b00});
      tbl.push_back('{mk(8,9,1,1,0, 0,1,8, 0,0,0, 0,0), 1'b0, 2'b00, 2'b00});
      tbl.push_back('{mk(8,9,0,0,1, 1,1,8, 1,0,8, 1,9), 1'b0, 2'b00, 2'b00});
      tbl.push_back('{mk(8,9,1,1,1, 1,0,9, 1,1,8, 0,0), 1'b1, 2'b00, 2'b00});

      foreach (tbl[i]) begin
         @(negedge Clock); Reset = 1'b1; drive(idle);
         @(negedge Clock); Reset = 1'b0; drive(tbl[i].in);
         #1 chkOut($sformatf("vec%0d", i), tbl[i].stall, tbl[i].fa, tbl[i].fb);
      end

      // ---------------- reset forces outputs regardless of inputs ----------------
      @(negedge Clock); Reset = 1'b1; drive(mk(5,5,1,1,1, 1,1,5, 1,0,5, 1,5));
      #1 chkOut("resetForce", 1'b0, 2'b00, 2'b00);
      @(negedge Clock); drive(idle);
      #1 chk("resetCount", StallCount, 32'd0);

      // ---------------- non-branch load-use: exactly one stall ----------------
      lwAdd     = mk(8,0,1,0,0, 1,1,8, 0,0,0, 0,0);
      lwAddNext = mk(8,0,1,0,0, 0,0,0, 1,1,8, 0,0);
      @(negedge Clock); Reset = 1'b0; drive(lwAdd);
      #1 chkOut("loadUse_c1", 1'b1, 2'b00, 2'b00);
      chk("loadUse_cnt0", StallCount, 32'd0);
      @(negedge Clock); drive(lwAddNext);
      #1 chkOut("loadUse_c2", 1'b0, 2'b00, 2'b00);
      chk("loadUse_cnt1", StallCount, 32'd1);

      // ---------------- branch after load: two stalls, then WB forward ----------------
      lwBeq     = mk(8,9,1,1,1, 1,1,8, 0,0,0, 0,0);
      lwBeqHold = mk(8,9,1,1,1, 0,0,0, 1,1,8, 0,0);
      lwBeqWb   = mk(8,9,1,1,1, 0,0,0, 0,0,0, 1,8);
      @(negedge Clock); Reset = 1'b1; drive(idle);
      @(negedge Clock); Reset = 1'b0; drive(lwBeq);
      #1 chkOut("lwBeq_c1", 1'b1, 2'b00, 2'b00);
      @(negedge Clock); drive(idle);
      #1 chkOut("lwBeq_holdIgnoresInputs", 1'b1, 2'b00, 2'b00);
      chk("lwBeq_cnt1", StallCount, 32'd1);
      @(negedge Clock); drive(lwBeqWb);
      #1 chkOut("lwBeq_release", 1'b0, 2'b01, 2'b00);
      chk("lwBeq_cnt2", StallCount, 32'd2);

      // ---------------- branch after ALU op: one stall, then MEM forward ----------------
      addBeq    = mk(8,9,1,1,1, 1,0,9, 0,0,0, 0,0);
      addBeqMem = mk(8,9,1,1,1, 0,0,0, 1,0,9, 0,0);
      @(negedge Clock); Reset = 1'b1; drive(idle);
      @(negedge Clock); Reset = 1'b0; drive(addBeq);
      #1 chkOut("addBeq_c1", 1'b1, 2'b00, 2'b00);
      @(negedge Clock); drive(addBeqMem);
      #1 chkOut("addBeq_c2", 1'b0, 2'b00, 2'b10);
      chk("addBeq_cnt", StallCount, 32'd1);

      // ---------------- reset during HOLD aborts the stall ----------------
      @(negedge Clock); Reset = 1'b1; drive(idle);
      @(negedge Clock); Reset = 1'b0; drive(lwBeq);
      #1 chkOut("rstHold_c1", 1'b1, 2'b00, 2'b00);
      @(negedge Clock); Reset = 1'b1; drive(lwBeqHold);
      #1 chkOut("rstHold_duringReset", 1'b0, 2'b00, 2'b00);
      @(negedge Clock); Reset = 1'b0; drive(idle);
      #1 chkOut("rstHold_runAfter", 1'b0, 2'b00, 2'b00);
      chk("rstHold_cnt", StallCount, 32'd0);
      @(negedge Clock); drive(lwBeq);
      #1 chkOut("rstHold_redetect", 1'b1, 2'b00, 2'b00);
      @(negedge Clock); drive(lwBeqHold);
      #1 chkOut("rstHold_redetectHold", 1'b1, 2'b00, 2'b00);

      // ---------------- saturation ----------------
      @(negedge Clock); Reset = 1'b1; drive(idle);
      @(negedge Clock); Reset = 1'b0; drive(idle);
      force dut.stallCnt = 32'hFFFF_FFFE;
      #1 release dut.stallCnt;
      #1 chk("sat_preload", StallCount, 32'hFFFF_FFFE);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock); drive(lwAdd);
         #1 chkOut($sformatf("sat_stall%0d", i), 1'b1, 2'b00, 2'b00);
      end
      @(negedge Clock); drive(idle);
      #1 chk("sat_hold", StallCount, 32'hFFFF_FFFF);

      // ---------------- randomized run against the reference model ----------------
      begin
         int     owed = 0;
         longint cnt  = 0;
         vec_t   v;
         int     nMax;
         logic   s, rst;
         logic [1:0] fa, fb;
         @(negedge Clock); Reset = 1'b1; drive(idle);
         for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge Clock);
            rst = ($urandom_range(0, 63) == 0);
            v = mk($urandom_range(0,3), $urandom_range(0,3), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), $urandom_range(0,3),
                   1'($urandom), 1'($urandom), $urandom_range(0,3),
                   1'($urandom), $urandom_range(0,3));
            Reset = rst;
            drive(v);
            #1;
            nMax = srcNeed(v.rs, v.uRs, v);
            if (srcNeed(v.rt, v.uRt, v) > nMax) nMax = srcNeed(v.rt, v.uRt, v);
            s  = !rst && (owed > 0 || nMax > 0);
            fa = rst ? 2'b00 : srcFwd(v.rs, v.uRs, v);
            fb = rst ? 2'b00 : srcFwd(v.rt, v.uRt, v);
            chkOut($sformatf("rand%0d_out", cyc), s, fa, fb);
            chk($sformatf("rand%0d_cnt", cyc), StallCount, 32'(cnt));
            if (rst) begin
               owed = 0;
               cnt  = 0;
            end else begin
               if (s && cnt < 64'hFFFF_FFFF) cnt++;
               if (owed > 0) owed--;
               else if (nMax > 0) owed = nMax - 1;
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_stall_controller.md
HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 SHALL have ports: Clock  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: Reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: ID_RsReg, ID_RtReg  in  5 each  source registers of the instruction in ID.
REQ-004 SHALL have ports: ID_UsesRs, ID_UsesRt  in  1 each  instruction in ID reads Rs / Rt.
REQ-005 SHALL have ports: Branch  in  1  ID instruction compares or consumes operands in ID (beq/bne/jr).
REQ-006 SHALL have ports: EX_RegWrite, EX_MemRead  in  1 each; EX_DestReg  in  5  final destination of the EX instruction.
REQ-007 SHALL have ports: MEM_RegWrite, MEM_MemRead  in  1 each; MEM_DestReg  in  5.
REQ-008 SHALL have ports: WB_RegWrite  in  1; WB_DestReg  in  5.
REQ-009 SHALL have ports: PCWrite, IFIDWrite  out  1 each  low = hold PC / IF-ID register.
REQ-010 SHALL have ports: HazZero  out  1  high = inject bubble into ID-EX control.
REQ-011 SHALL have ports: ForBranchA, ForBranchB  out  2 each  ID comparator operand select: 00 register file, 01 WB write data, 10 MEM ALU output.
REQ-012 SHALL have ports: StallCount  out  32  stall-cycle counter.

Function
REQ-013 SHALL define a match as: the source register is used, is nonzero, and equals the producer's destination with the producer's RegWrite=1.
REQ-014 SHALL define the stall need for each source register:
- non-branch, EX load match: 1
- branch, EX load match: 2
- branch, EX ALU match (RegWrite=1, MemRead=0): 1
- branch, MEM load match: 1
- otherwise: 0
REQ-015 SHALL take Need as the maximum over Rs and Rt.
REQ-016 SHALL implement the FSM states RUN and HOLD, with a 2-bit Remaining counter.
REQ-017 In RUN with Need>0, SHALL assert Stall in the same cycle (combinationally) and load Remaining=Need-1.
REQ-017a On that RUN cycle, SHALL go to HOLD if Need-1>0, else stay in RUN.
REQ-018 In HOLD, SHALL assert Stall unconditionally, ignore hazard inputs, and decrement Remaining.
REQ-018a SHALL return to RUN on the cycle Remaining reaches 0; RUN re-evaluates hazards.
REQ-019 While Stall=1, SHALL drive PCWrite=0, IFIDWrite=0 and HazZero=1; otherwise 1, 1, 0.
REQ-020 SHALL compute ForBranchA/B combinationally every cycle, including stall cycles.
REQ-020a ForBranch priority:
- 10 if MEM match and MEM_MemRead=0
- else 01 if WB match
- else 00
REQ-021 SHALL never forward for register 0; a MEM load match SHALL yield 00 or 01, never 10.
REQ-022 SHALL increment StallCount by 1 on each rising edge where Stall=1, saturating at 32'hFFFFFFFF without wrap.
REQ-023 When Rs and Rt hazards occur simultaneously with different needs, SHALL stall for the larger need only, not the sum.
REQ-024 SHALL add no latency to hazard detection: the first stall cycle coincides with the instruction's first cycle in ID.

Reset
REQ-025 On a rising edge with Reset=1, SHALL set state=RUN, Remaining=0 and StallCount=0.
REQ-026 While Reset=1, SHALL force PCWrite=1, IFIDWrite=1, HazZero=0 and ForBranchA/B=00, regardless of inputs.
REQ-027 Reset asserted during HOLD SHALL abort the stall; the first cycle after reset SHALL be RUN, with detection from current inputs.

Structure
REQ-028 SHALL place the following in shared package hazard_pkg:
- state encoding (RUN, HOLD)
- forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
- COUNT_MAX
REQ-029 SHALL instantiate sub-module hazard_src_eval twice (Rs, Rt); each computes its source's stall need and forward select.
REQ-029a The FSM, max-need logic and StallCount SHALL reside in the top module.

Verification
REQ-030 Non-branch load-use: EX lw $t0 (EX_DestReg=8, EX_MemRead=1), ID add reading Rs=8 -> exactly 1 cycle PCWrite=0/HazZero=1; StallCount 0->1.
REQ-031 Branch after load: EX lw $8; ID beq $8,$9 -> Stall for 2 consecutive cycles (RUN then HOLD).
REQ-031a After those 2 cycles -> ForBranchA=01 with load in WB; StallCount=2.
REQ-032 Branch after ALU op: EX add $9; ID beq $8,$9 -> 1 stall cycle, then ForBranchB=10 with add in MEM.
REQ-033 Register 0 and priority:
- EX lw $0 with ID beq $0,$0 -> no stall, ForBranch=00
- MEM and WB both writing $5 -> ForBranchA=10
REQ-034 Reset mid-HOLD: Reset=1 on the second stall cycle -> PCWrite=1 during reset, StallCount=0, state RUN next cycle.
REQ-035 Saturation: preload via 2^32-1 stall cycles (or force) -> StallCount stays 32'hFFFFFFFF on further stalls.
